sample_recorder: RTL
====================

# sample_recorder

Captures a fixed-length record of a sample stream at a programmable clock-divided rate into an on-chip buffer, then allows random-access readback. It is the consuming end of the SPWM sample path: where the generator plays a stored waveform out at a set rate, this block records a live waveform in at a set rate. It is used for modulator debug and for loading measured waveforms into tables.

## Interface
Parameters:
- SIGNAL_SAMPLE_BITS, 32, width of one sample.
- DEPTH_LOG2, 8, log2 of record length; DEPTH = 2**DEPTH_LOG2 samples.

Ports:
- clk  in  1  single system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low; one clock, reset is synchronous and active-low.
- sample_in  in  SIGNAL_SAMPLE_BITS  live sample to record.
- clks_per_sample  in  20  sample period in clk cycles; latched on start; 0 treated as 1.
- start  in  1  level-sampled request to begin a record.
- abort  in  1  cancel an in-progress record.
- rd_en  in  1  readback request.
- rd_addr  in  DEPTH_LOG2  readback index.
- busy  out  1  record in progress.
- done  out  1  full record available.
- wr_count  out  DEPTH_LOG2+1  samples written in the current/last record.
- rd_data  out  SIGNAL_SAMPLE_BITS  readback data.
- rd_valid  out  1  rd_data valid strobe.

## Operation
- FSM states: IDLE, CAPTURE, DONE.
- IDLE/DONE + start=1, abort=0 -> CAPTURE. Same edge: period_reg <= max(clks_per_sample,1), clk_cnt <= 0, wr_count <= 0, done <= 0, busy <= 1.
- CAPTURE, each cycle:
  - If clk_cnt == period_reg-1: write sample_in to buffer[wr_count], wr_count++, clk_cnt <= 0.
  - Otherwise clk_cnt++.
  - start is ignored.
- Write that makes wr_count == DEPTH -> DONE the same edge; busy <= 0, done <= 1.
- abort=1 in CAPTURE -> IDLE next edge. busy <= 0, done <= 0; wr_count holds partial count; the sample due on that edge is not written.
- abort and start in the same cycle: abort wins; no record starts.
- Readback: rd_en=1 in IDLE or DONE -> rd_data <= buffer[rd_addr] and rd_valid <= 1 on the next edge, a one-cycle pulse. In CAPTURE, rd_en is ignored and rd_valid stays 0.
- Arithmetic:
  - clk_cnt is 20 bits unsigned.
  - wr_count has DEPTH_LOG2+1 bits; the buffer index uses its low DEPTH_LOG2 bits.
  - No wrap beyond DEPTH: capture stops at DEPTH.

## Timing
- reset=0 at an edge: state IDLE; busy=0, done=0, wr_count=0, rd_valid=0, rd_data=0, clk_cnt=0, period_reg=1. Applies mid-capture as well. Buffer contents are not cleared and are unspecified after reset.
- Let edge E be the edge accepting start. The first sample is captured at edge E+P, and sample k (0-based) at edge E+(k+1)·P.
- done rises at edge E+DEPTH·P.
- P=1: one sample per cycle, consecutive edges.
- Changing clks_per_sample during CAPTURE has no effect until the next start.
- Read latency is 1 cycle. Back-to-back rd_en gives one result per cycle.
- start while in DONE re-arms immediately. done falls on the acceptance edge.

## Structure
- Shared package spwm_pkg:
  - SIGNAL_SAMPLE_BITS default.
  - recorder state enum (IDLE, CAPTURE, DONE).
  - Constant PERIOD_BITS = 20, shared with the generator frequency width.
- Sub-module sample_ram:
  - Simple dual-port memory, DEPTH × SIGNAL_SAMPLE_BITS.
  - One synchronous write port and one registered read port, no reset.
  - Infers block RAM.
- The top holds the FSM, divider counter, wr_count and output registers.

## Test plan
- Reset mid-capture: start with P=4, assert reset=0 after 10 cycles -> next edge busy=0, done=0, wr_count=0, rd_valid=0.
- Full record, DEPTH_LOG2=3, P=3, sample_in = cycle count -> done rises exactly 24 cycles after the start edge, wr_count=8. Readback of addr 0..7 gives values spaced by 3, rd_valid one cycle after each rd_en.
- P=0 and P=1 -> both capture every cycle; 8 samples arrive in 8 cycles.
- Abort after 5 samples (P=2), with start held high in the same cycle -> IDLE, wr_count=5, busy=0, no new record begins.
- Read during CAPTURE -> rd_valid stays 0. Change clks_per_sample from 3 to 7 mid-record -> sample spacing stays 3.
- Re-arm from DONE -> done falls on the acceptance edge, wr_count resets to 0, and the second record overwrites the buffer.

Source files
------------

// File: rtl/spwm_pkg.sv
// spwm_pkg: definitions shared by the SPWM sample path (generator and recorder).
package spwm_pkg;

    // Default width of one signal sample.
    localparam int SIGNAL_SAMPLE_BITS_DEFAULT = 32;

    // Width of sample-period counters, shared with the generator frequency width.
    localparam int PERIOD_BITS = 20;

    // Recorder control states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } recorder_state_t;

    // A programmed period of zero behaves like one clock per sample.
    function automatic logic [PERIOD_BITS-1:0] clampPeriod(input logic [PERIOD_BITS-1:0] period);
        return (period == '0) ? PERIOD_BITS'(1) : period;
    endfunction

endpackage

// File: rtl/sample_ram.sv
// sample_ram: simple dual-port buffer, one synchronous write port and one
// registered read port. No reset so that it maps onto block RAM.
module sample_ram #(
    parameter int DATA_BITS = 32,
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 i_wrEn,
    input  logic [ADDR_BITS-1:0] i_wrAddr,
    input  logic [DATA_BITS-1:0] i_wrData,
    input  logic                 i_rdEn,
    input  logic [ADDR_BITS-1:0] i_rdAddr,
    output logic [DATA_BITS-1:0] o_rdData
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [DATA_BITS-1:0] r_mem [0:DEPTH-1];
    logic [DATA_BITS-1:0] r_rdData;

    // Store the incoming sample at the write address when a write is requested.
    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    // Registered read; the output holds its last value between reads.
    always_ff @(posedge clk) begin
        if (i_rdEn) begin
            r_rdData <= r_mem[i_rdAddr];
        end
    end

    assign o_rdData = r_rdData;

endmodule

// File: rtl/sample_recorder.sv
// sample_recorder: records a fixed-length block of a live sample stream at a
// programmable clock-divided rate, then serves random-access readback.
module sample_recorder
    import spwm_pkg::*;
#(
    parameter int SIGNAL_SAMPLE_BITS = SIGNAL_SAMPLE_BITS_DEFAULT,
    parameter int DEPTH_LOG2         = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [SIGNAL_SAMPLE_BITS-1:0] sample_in,
    input  logic [PERIOD_BITS-1:0]        clks_per_sample,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          rd_en,
    input  logic [DEPTH_LOG2-1:0]         rd_addr,
    output logic                          busy,
    output logic                          done,
    output logic [DEPTH_LOG2:0]           wr_count,
    output logic [SIGNAL_SAMPLE_BITS-1:0] rd_data,
    output logic                          rd_valid
);

    // Count value that marks a complete record (DEPTH samples).
    localparam logic [DEPTH_LOG2:0] DEPTH_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    recorder_state_t                 r_state;
    logic [PERIOD_BITS-1:0]          r_period;
    logic [PERIOD_BITS-1:0]          r_clkCnt;
    logic [DEPTH_LOG2:0]             r_wrCount;
    logic                            r_busy;
    logic                            r_done;
    logic                            r_rdValid;
    logic                            r_rdLoaded;

    logic                            w_sampleDue;
    logic                            w_wrEn;
    logic [DEPTH_LOG2:0]             w_wrCountNext;
    logic                            w_rdAccept;
    logic [SIGNAL_SAMPLE_BITS-1:0]   w_ramData;

    // The divider reaches its last count on the edge that owes a sample.
    assign w_sampleDue   = (r_clkCnt == (r_period - PERIOD_BITS'(1)));
    // An abort on the due edge suppresses that sample.
    assign w_wrEn        = (r_state == CAPTURE) && !abort && w_sampleDue;
    assign w_wrCountNext = r_wrCount + (DEPTH_LOG2 + 1)'(1);
    // Readback is refused while a record is being written.
    assign w_rdAccept    = rd_en && (r_state != CAPTURE);

    sample_ram #(
        .DATA_BITS (SIGNAL_SAMPLE_BITS),
        .ADDR_BITS (DEPTH_LOG2)
    ) u_sample_ram (
        .clk      (clk),
        .i_wrEn   (w_wrEn),
        .i_wrAddr (r_wrCount[DEPTH_LOG2-1:0]),
        .i_wrData (sample_in),
        .i_rdEn   (w_rdAccept),
        .i_rdAddr (rd_addr),
        .o_rdData (w_ramData)
    );

    // Record FSM with divider, write counter and registered status/readback flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_period   <= PERIOD_BITS'(1);
            r_clkCnt   <= '0;
            r_wrCount  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rdValid  <= 1'b0;
            r_rdLoaded <= 1'b0;
        end else begin
            r_rdValid <= w_rdAccept;
            if (w_rdAccept) begin
                r_rdLoaded <= 1'b1;
            end

            case (r_state)
                IDLE, DONE: begin
                    if (start && !abort) begin
                        r_state   <= CAPTURE;
                        r_period  <= clampPeriod(clks_per_sample);
                        r_clkCnt  <= '0;
                        r_wrCount <= '0;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                    end
                end

                CAPTURE: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else if (w_sampleDue) begin
                        r_wrCount <= w_wrCountNext;
                        r_clkCnt  <= '0;
                        if (w_wrCountNext == DEPTH_COUNT) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_clkCnt <= r_clkCnt + PERIOD_BITS'(1);
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign wr_count = r_wrCount;
    assign rd_valid = r_rdValid;
    // Read data reads as zero until the first readback after reset.
    assign rd_data  = r_rdLoaded ? w_ramData : '0;

endmodule
